// File: rtl/coremacfilter_cdc_xfer_arb.sv
// Source-side round-robin arbiter that shares one toggle-handshake CDC channel between NUM_REQ requesters.
// Optional WAIT_ACK timeout and ERR state are enabled by defining CDC_XFER_TIMEOUT_EN.
module coremacfilter_cdc_xfer_arb #(
  parameter int NUM_REQ        = 4,
  parameter int DWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_W       = 11
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DWIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      busy_o,
  output logic [DWIDTH-1:0]         xfer_data_o,
  output logic                      xfer_req_tgl_o,
  input  logic                      xfer_ack_tgl_i,
  output logic                      err_o,
  output logic [2:0]                err_id_o
);

  localparam int          PW  = $clog2(NUM_REQ);
  localparam int unsigned NR  = NUM_REQ;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2**TO_CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("coremacfilter_cdc_xfer_arb: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     sel_nxt;
  logic [PW-1:0]     cand;
  logic              cand_vld;
  logic              ack_m;
  logic              ack_s;
  logic              ack_d;
  logic              ack_hit;
  logic [DWIDTH-1:0] words [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
    assign words[k] = data_i[k*DWIDTH +: DWIDTH];
  end

  // ack_d is an edge detector behind the 2-flop synchroniser: only an ack_s
  // transition seen in WAIT_ACK/ERR counts, so stray toggles never complete a transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
      ack_d <= 1'b0;
    end else begin
      ack_m <= xfer_ack_tgl_i;
      ack_s <= ack_m;
      ack_d <= ack_s;
    end
  end

  assign ack_hit = (ack_s != ack_d) && (ack_s == xfer_req_tgl_o);
  assign sel_nxt = (sel == PW'(NUM_REQ-1)) ? '0 : sel + 1'b1;

  always_comb begin
    int unsigned idx;
    idx      = 0;
    cand     = '0;
    cand_vld = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NR) idx = idx - NR;
      if (!cand_vld && req_i[PW'(idx)]) begin
        cand_vld = 1'b1;
        cand     = PW'(idx);
      end
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      sel            <= '0;
      gnt_o          <= '0;
      done_o         <= '0;
      busy_o         <= 1'b0;
      xfer_data_o    <= '0;
      xfer_req_tgl_o <= 1'b0;
`ifdef CDC_XFER_TIMEOUT_EN
      to_cnt         <= '0;
      err_o          <= 1'b0;
      err_id_o       <= '0;
`endif
    end else begin
      gnt_o  <= '0;
      done_o <= '0;
      case (state)
        ST_IDLE: begin
          if (cand_vld) begin
            sel         <= cand;
            xfer_data_o <= words[cand];
            gnt_o       <= ONE << cand;
            busy_o      <= 1'b1;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          xfer_req_tgl_o <= ~xfer_req_tgl_o;
`ifdef CDC_XFER_TIMEOUT_EN
          to_cnt         <= '0;
`endif
          state          <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_hit) begin
            done_o <= ONE << sel;
            state  <= ST_DONE;
          end
`ifdef CDC_XFER_TIMEOUT_EN
          else if (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES-1)) begin
            err_o    <= 1'b1;
            err_id_o <= 3'(sel);
            state    <= ST_ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          ptr    <= sel_nxt;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
`ifdef CDC_XFER_TIMEOUT_EN
        ST_ERR: begin
          if (ack_hit) begin
            err_o  <= 1'b0;
            ptr    <= sel_nxt;
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end
`endif
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef CDC_XFER_TIMEOUT_EN
  assign err_o    = 1'b0;
  assign err_id_o = '0;
`endif

endmodule

// File: tb/tb_coremacfilter_cdc_xfer_arb.sv
// Randomised scoreboard bench for coremacfilter_cdc_xfer_arb with a destination echo model.
// Timeout checks run only when CDC_XFER_TIMEOUT_EN is defined.
module tb_coremacfilter_cdc_xfer_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_i = 1'b1;
  logic [N-1:0]   req_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   done_o;
  logic           busy_o;
  logic [W-1:0]   xfer_data_o;
  logic           xfer_req_tgl_o;
  logic           xfer_ack_tgl_i = 1'b0;
  logic           err_o;
  logic [2:0]     err_id_o;

  coremacfilter_cdc_xfer_arb #(
    .NUM_REQ(N), .DWIDTH(W), .TIMEOUT_CYCLES(16), .TO_CNT_W(5)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
    .xfer_data_o(xfer_data_o), .xfer_req_tgl_o(xfer_req_tgl_o),
    .xfer_ack_tgl_i(xfer_ack_tgl_i), .err_o(err_o), .err_id_o(err_id_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [W-1:0] data;
    bit         first;
    int         icyc;
  } ent_t;

  ent_t gq[$];
  ent_t dq[$];
  int   total = 0;
  int   bad = 0;
  int   mdl_ptr = 0;
  int   gnt_cnt = 0;
  int   done_cnt = 0;
  int   last_ack_cyc = 0;
  bit   echo_en = 1'b1;
  int   echo_dly = 3;
  bit   stray_req = 1'b0;
  bit   hold_all = 1'b0;
  logic tgl_exp = 1'b0;
  bit   chk_tgl = 1'b0;
  bit   chk_idle = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [N-1:0] onehot(int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Requesters drop req_i on their grant and scramble their word afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold_all) begin
      for (int i = 0; i < N; i++) begin
        if (gnt_o[i]) begin
          req_i[i] = 1'b0;
          data_i[i*W +: W] = $urandom;
        end
      end
    end
  endtask

  // Reference arbitration: a set raised together is served in cyclic order from the pointer.
  task automatic issue(input logic [N-1:0] m, input bit keep_data);
    int last;
    bit first;
    last = -1;
    first = 1'b1;
    for (int i = 0; i < N; i++)
      if (m[i] && !keep_data) data_i[i*W +: W] = $urandom;
    for (int k = 0; k < N; k++) begin
      int id;
      ent_t e;
      id = (mdl_ptr + k) % N;
      if (m[id]) begin
        e.id = id;
        e.data = data_i[id*W +: W];
        e.first = first;
        e.icyc = cyc;
        gq.push_back(e);
        first = 1'b0;
        last = id;
      end
    end
    if (last >= 0) mdl_ptr = (last + 1) % N;
    req_i = req_i | m;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(gq.size() == 0 && dq.size() == 0 && busy_o == 1'b0) && n < budget);
    if (!(gq.size() == 0 && dq.size() == 0 && busy_o == 1'b0)) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got busy=%0b pending=%0d expected idle within %0d cycles",
               tag, busy_o, gq.size() + dq.size(), budget);
    end
  endtask

  // Destination model: echoes the request toggle echo_dly cycles after seeing it.
  initial begin
    int cnt_dn;
    cnt_dn = -1;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        xfer_ack_tgl_i = 1'b0;
        cnt_dn = -1;
      end else if (stray_req) begin
        xfer_ack_tgl_i = ~xfer_ack_tgl_i;
        stray_req = 1'b0;
      end else if (echo_en) begin
        if (cnt_dn > 0) cnt_dn--;
        if (cnt_dn == 0) begin
          xfer_ack_tgl_i = xfer_req_tgl_o;
          last_ack_cyc = cyc;
          cnt_dn = -1;
        end else if (cnt_dn < 0 && xfer_req_tgl_o != xfer_ack_tgl_i) begin
          cnt_dn = echo_dly;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or a done.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        gq.delete();
        dq.delete();
        tgl_exp = 1'b0;
        chk_tgl = 1'b0;
        chk_idle = 1'b0;
      end else begin
        if (chk_tgl) begin
          chk("req_toggle", xfer_req_tgl_o, tgl_exp);
          chk_tgl = 1'b0;
        end
        if (chk_idle) begin
          chk("busy_after_done", busy_o, 0);
          chk_idle = 1'b0;
        end
        if (gnt_o != '0) begin
          gnt_cnt++;
          if (gq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL gnt_unexpected: got %b expected none", gnt_o);
          end else begin
            e = gq.pop_front();
            chk("gnt_onehot", gnt_o, onehot(e.id));
            chk("gnt_data", xfer_data_o, e.data);
            chk("busy_on_gnt", busy_o, 1);
            if (e.first) chk("gnt_latency", cyc, e.icyc + 1);
            tgl_exp = ~tgl_exp;
            chk_tgl = 1'b1;
            dq.push_back(e);
          end
        end
        if (done_o != '0) begin
          done_cnt++;
          if (dq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got %b expected none", done_o);
          end else begin
            e = dq.pop_front();
            chk("done_onehot", done_o, onehot(e.id));
            chk("done_latency", cyc, last_ack_cyc + 3);
            chk("hold_data", xfer_data_o, e.data);
`ifndef CDC_XFER_TIMEOUT_EN
            chk("err_tied_low", {err_o, err_id_o}, 0);
`endif
            chk_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int   dc;
    int   n;
    int   id;
    int   gstart;
    int   tgl_cyc;
    logic old;
    logic exp_t;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {gnt_o, done_o, busy_o, xfer_data_o, xfer_req_tgl_o, err_o, err_id_o}, 0);
    rst_i = 1'b0;
    tick();

    // Single request with a fixed word
    echo_dly = 4;
    data_i[2*W +: W] = 32'hDEADBEEF;
    issue(4'b0100, 1'b1);
    wait_idle(100, "single");

    // All requesters held high: five grants in rotation
    echo_dly = 1;
    for (int i = 0; i < N; i++) data_i[i*W +: W] = $urandom;
    gstart = gnt_cnt;
    for (int k = 0; k < 5; k++) begin
      ent_t e;
      e.id = (mdl_ptr + k) % N;
      e.data = data_i[e.id*W +: W];
      e.first = (k == 0);
      e.icyc = cyc;
      gq.push_back(e);
    end
    mdl_ptr = (mdl_ptr + 5) % N;
    hold_all = 1'b1;
    req_i = '1;
    n = 0;
    while (gnt_cnt < gstart + 5 && n < 300) begin
      tick();
      n++;
    end
    req_i = '0;
    hold_all = 1'b0;
    chk("hold_grant_count", gnt_cnt - gstart, 5);
    wait_idle(100, "hold");

    // Random batches with random echo delays
    for (int b = 0; b < 30; b++) begin
      echo_dly = $urandom_range(1, 6);
      issue(N'($urandom_range(1, 15)), 1'b0);
      wait_idle(400, "random");
    end

    // Stray ack toggle while idle must not complete the next transfer
    echo_en = 1'b0;
    stray_req = 1'b1;
    repeat (8) tick();
    dc = done_cnt;
    id = $urandom_range(0, N-1);
    issue(onehot(id), 1'b0);
    repeat (30) tick();
    chk("stray_no_done", done_cnt, dc);
    chk("stray_busy", busy_o, 1);
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    mdl_ptr = 0;
    echo_en = 1'b1;
    echo_dly = 3;
    tick();
    issue(N'($urandom_range(1, 15)), 1'b0);
    wait_idle(400, "after_stray");

    // Asynchronous reset two cycles after the request toggle
    dc = done_cnt;
    echo_dly = 8;
    issue(onehot($urandom_range(0, N-1)), 1'b0);
    old = xfer_req_tgl_o;
    n = 0;
    while (xfer_req_tgl_o == old && n < 10) begin
      tick();
      n++;
    end
    exp_t = ~old;
    chk("tgl_before_reset", xfer_req_tgl_o, exp_t);
    tick();
    tick();
    #1 rst_i = 1'b1;
    #1 chk("async_reset_outputs",
           {gnt_o, done_o, busy_o, xfer_data_o, xfer_req_tgl_o, err_o, err_id_o}, 0);
    repeat (3) tick();
    rst_i = 1'b0;
    mdl_ptr = 0;
    tick();
    chk("reset_no_done", done_cnt, dc);
    echo_dly = 2;
    issue(N'($urandom_range(1, 15)), 1'b0);
    wait_idle(400, "after_reset");

`ifdef CDC_XFER_TIMEOUT_EN
    // Missing echo: timeout into ERR, then a late echo recovers
    echo_en = 1'b0;
    dc = done_cnt;
    id = $urandom_range(0, N-1);
    issue(onehot(id), 1'b0);
    old = xfer_req_tgl_o;
    n = 0;
    while (xfer_req_tgl_o == old && n < 10) begin
      tick();
      n++;
    end
    tgl_cyc = cyc;
    n = 0;
    while (!err_o && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", cyc, tgl_cyc + 16);
    chk("err_id", err_id_o, id);
    chk("timeout_no_done", done_cnt, dc);
    chk("busy_in_err", busy_o, 1);
    dq.delete();
    echo_dly = 2;
    echo_en = 1'b1;
    n = 0;
    while (err_o && n < 40) begin
      tick();
      n++;
    end
    chk("err_clear_latency", cyc, last_ack_cyc + 3);
    chk("idle_after_err", busy_o, 0);
    issue(4'hF, 1'b0);
    wait_idle(400, "after_err");
`else
    tgl_cyc = 0;
    gstart = tgl_cyc;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
